multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM for the multicycle MIPS core; drives every control input of the datapath.
//  Consumes the datapath's latched instruction and ALU overflow flag.
//  One instruction every 3-5 cycles; no pipelining. Memory write strobe goes to the unified memory.
// PARAMETERS
//  TRAP_EN  1  1: signed-overflow on add/sub/addi suppresses the register write and pulses trap; 0: ignore overflow
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous, active-high reset
//  instruction  in   32  IR contents from datapath; opcode [31:26], funct [5:0]
//  overflow     in   1   ALU signed overflow, combinational from datapath
//  PCSource     out  2   00 ALUResult, 01 ALUOut, 10 jump target
//  ALUSrcB      out  2   00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  ALUSrcA      out  1   0 PC, 1 A
//  RegWrite     out  1   regfile write enable
//  RegDst       out  1   0 rt, 1 rd
//  PCWriteCond  out  1   PC write if ALU Zero
//  PCWrite      out  1   unconditional PC write
//  IorD         out  1   0 PC, 1 ALUOut as memory address
//  MemToReg     out  1   0 ALUOut, 1 Data register
//  IRWrite      out  1   IR load enable
//  MemWrite     out  1   memory write strobe
//  ALUControl   out  4   0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
//  trap         out  1   one-cycle pulse: overflow-suppressed write (TRAP_EN=1)
//  illegal      out  1   one-cycle pulse in DECODE on unsupported opcode/funct
//  state_o      out  4   current state code, debug
// BEHAVIOUR
//  - Moore FSM. All outputs decode from the state register, plus the latched ovf flag for RegWrite/trap.
//  - While rst=1, every output is forced to 0. The first rising edge with rst=0 is evaluated in FETCH.
//  - Reset mid-instruction abandons the instruction. No write strobe is asserted in the reset cycle.
//  - Unlisted outputs are 0 in every state.
//  - FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00, PCWrite=1. Next state is DECODE.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut). Dispatch on opcode:
//      lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BRANCH;
//      addi 001000 -> ADDIEXEC; j 000010 -> JUMP; other -> FETCH with illegal=1.
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next state is MEMRD for lw, MEMWR for sw.
//  - MEMRD: IorD=1 -> MEMWB. MEMWB: RegDst=0, MemToReg=1, RegWrite=1 -> FETCH.
//  - MEMWR: IorD=1, MemWrite=1 -> FETCH.
//  - EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUControl comes from funct:
//      add 100000 / addu 100001 -> ADD; sub 100010 / subu 100011 -> SUB; and 100100 -> AND;
//      or 100101 -> OR; nor 100111 -> NOR; slt 101010 -> SLT.
//    Other funct -> FETCH with illegal=1 and no write. Otherwise -> ALUWB.
//  - ALUWB: RegDst=1, MemToReg=0, RegWrite=1 -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWriteCond=1 -> FETCH.
//  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB. ADDIWB: RegDst=0, MemToReg=0, RegWrite=1 -> FETCH.
//  - JUMP: PCSource=10, PCWrite=1 -> FETCH.
//  - Overflow: ovf flag is registered at the end of EXECUTE/ADDIEXEC for add, sub and addi only.
//    It is cleared in FETCH. With TRAP_EN=1 and ovf=1, the ALUWB/ADDIWB cycle has RegWrite=0 and trap=1.
//    addu/subu never trap.
//  - Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
//  - instruction is sampled in DECODE/EXECUTE etc. Stability is guaranteed by the IR (IRWrite only in FETCH).
// STRUCTURE
//  - Shared package: state encodings (FETCH=0..JUMP=11), opcode and funct constants, ALUControl codes,
//    ALUSrcB/PCSource select codes.
//  - Sub-module alu_decoder: (aluop[1:0], funct[5:0]) -> ALUControl, funct_ok. Combinational, reused by tests.
//  - The FSM stays in this file; next-state and output decode are separate always blocks.
// TESTING
//  - Reset, then lw 0x8C220004: states FETCH, DECODE, MEMADR, MEMRD, MEMWB.
//    Required: IorD=1 in MEMRD; RegWrite=1, MemToReg=1, RegDst=0 in MEMWB only; PCWrite only in FETCH.
//  - sw 0xAC220008: MemWrite=1 for exactly one cycle (MEMWR), RegWrite never asserted, back to FETCH after 4 cycles.
//  - R-type sequence add/sub/and/or/nor/slt (funct 20,22,24,25,27,2A):
//    ALUControl in EXECUTE = 0010, 0110, 0000, 0001, 1100, 0111; RegDst=1 in ALUWB.
//  - beq 0x10220003: DECODE shows ALUSrcB=11; BRANCH shows PCWriteCond=1, PCSource=01, ALUControl=0110.
//    j 0x08000010: PCSource=10, PCWrite=1.
//  - addi with overflow=1 driven during ADDIEXEC, TRAP_EN=1 -> ADDIWB has RegWrite=0, trap=1.
//    Same stimulus on addu -> RegWrite=1, trap=0.
//  - Opcode 0x3F -> illegal=1 in DECODE, FETCH next. Assert rst during MEMWR -> MemWrite=0 that cycle, FETCH after release.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcodes,
// funct codes, ALU control codes and datapath mux selects.
package multicycle_controller_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Only the signed forms may raise a trap; addu/subu wrap silently.
  function automatic logic is_trapping_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction/overflow from the datapath,
// every datapath control plus debug state from the controller.
interface multicycle_controller_if;
  logic [31:0] instruction;
  logic        overflow;
  logic [1:0]  PCSource;
  logic [1:0]  ALUSrcB;
  logic        ALUSrcA;
  logic        RegWrite;
  logic        RegDst;
  logic        PCWriteCond;
  logic        PCWrite;
  logic        IorD;
  logic        MemToReg;
  logic        IRWrite;
  logic        MemWrite;
  logic [3:0]  ALUControl;
  logic        trap;
  logic        illegal;
  logic [3:0]  state_o;

  modport master (
    input  instruction, overflow,
    output PCSource, ALUSrcB, ALUSrcA, RegWrite, RegDst, PCWriteCond, PCWrite,
           IorD, MemToReg, IRWrite, MemWrite, ALUControl, trap, illegal, state_o
  );

  modport slave (
    output instruction, overflow,
    input  PCSource, ALUSrcB, ALUSrcA, RegWrite, RegDst, PCWriteCond, PCWrite,
           IorD, MemToReg, IRWrite, MemWrite, ALUControl, trap, illegal, state_o
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode: fixed ADD/SUB for address and branch work, funct-driven
// for R-type; funct_ok flags whether funct is a supported R-type operation.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_control,
  output logic        funct_ok
);

  logic [3:0] funct_ctrl;

  always_comb begin
    funct_ctrl = ALU_ADD;
    funct_ok   = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: funct_ctrl = ALU_ADD;
      FN_SUB, FN_SUBU: funct_ctrl = ALU_SUB;
      FN_AND:          funct_ctrl = ALU_AND;
      FN_OR:           funct_ctrl = ALU_OR;
      FN_NOR:          funct_ctrl = ALU_NOR;
      FN_SLT:          funct_ctrl = ALU_SLT;
      default:         funct_ok   = 1'b0;
    endcase
  end

  always_comb begin
    case (aluop)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = funct_ctrl;
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS core; one instruction every 3-5
// cycles, outputs decoded from the state register and the latched overflow.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit TRAP_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  logic [3:0] state;
  logic [3:0] state_next;
  logic       ovf;
  logic       trap_hit;
  logic [5:0] opcode;
  logic [5:0] funct;
  aluop_t     aluop;
  logic [3:0] alu_control;
  logic       funct_ok;
  logic       op_known;
  logic       unused_instr_bits;

  assign opcode            = bus.instruction[31:26];
  assign funct             = bus.instruction[5:0];
  assign unused_instr_bits = ^bus.instruction[25:6];
  assign trap_hit          = TRAP_EN & ovf;

  always_comb begin
    case (state)
      S_BRANCH:  aluop = ALUOP_SUB;
      S_EXECUTE: aluop = ALUOP_FUNCT;
      default:   aluop = ALUOP_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct       (funct),
    .alu_control (alu_control),
    .funct_ok    (funct_ok)
  );

  always_comb begin
    op_known = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_known = 1'b1;
      OP_RTYPE:                            op_known = funct_ok;
      default:                             op_known = 1'b0;
    endcase
  end

  // The overflow flag only captures signed add/sub/addi results and is wiped
  // in FETCH so a stale flag can never leak into the next instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_FETCH)
        ovf <= 1'b0;
      else if ((state == S_EXECUTE && is_trapping_funct(funct)) || state == S_ADDIEXEC)
        ovf <= bus.overflow;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = funct_ok ? S_EXECUTE : S_FETCH;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEXEC;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_next = S_MEMWB;
      S_EXECUTE:  state_next = funct_ok ? S_ALUWB : S_FETCH;
      S_ADDIEXEC: state_next = S_ADDIWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Everything is held at zero while rst is high, so no strobe escapes in the
  // cycle an instruction is abandoned.
  always_comb begin
    bus.PCSource    = PCSRC_ALU;
    bus.ALUSrcB     = SRCB_B;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.ALUControl  = 4'b0000;
    bus.trap        = 1'b0;
    bus.illegal     = 1'b0;
    bus.state_o     = 4'd0;
    if (!rst) begin
      bus.state_o = state;
      case (state)
        S_FETCH: begin
          bus.IRWrite    = 1'b1;
          bus.ALUSrcB    = SRCB_FOUR;
          bus.ALUControl = alu_control;
          bus.PCWrite    = 1'b1;
        end
        S_DECODE: begin
          bus.ALUSrcB    = SRCB_IMM_SH;
          bus.ALUControl = alu_control;
          bus.illegal    = ~op_known;
        end
        S_MEMADR: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUSrcB    = SRCB_IMM;
          bus.ALUControl = alu_control;
        end
        S_MEMRD: bus.IorD = 1'b1;
        S_MEMWB: begin
          bus.MemToReg = 1'b1;
          bus.RegWrite = 1'b1;
        end
        S_MEMWR: begin
          bus.IorD     = 1'b1;
          bus.MemWrite = 1'b1;
        end
        S_EXECUTE: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUControl = alu_control;
          bus.illegal    = ~funct_ok;
        end
        S_ALUWB: begin
          bus.RegDst   = 1'b1;
          bus.RegWrite = ~trap_hit;
          bus.trap     = trap_hit;
        end
        S_BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUControl  = alu_control;
          bus.PCSource    = PCSRC_ALUOUT;
          bus.PCWriteCond = 1'b1;
        end
        S_ADDIEXEC: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUSrcB    = SRCB_IMM;
          bus.ALUControl = alu_control;
        end
        S_ADDIWB: begin
          bus.RegWrite = ~trap_hit;
          bus.trap     = trap_hit;
        end
        S_JUMP: begin
          bus.PCSource = PCSRC_JUMP;
          bus.PCWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class state
// by state and compares the full control word against hand-built constants.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

  multicycle_controller_if bus ();

  multicycle_controller #(.TRAP_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {PCSource, ALUSrcB, ALUSrcA,
  //  RegWrite, RegDst, PCWriteCond, PCWrite, IorD, MemToReg, IRWrite, MemWrite,
  //  ALUControl, trap, illegal, state}
  logic [22:0] ctrl;
  assign ctrl = {bus.PCSource, bus.ALUSrcB, bus.ALUSrcA,
                 bus.RegWrite, bus.RegDst, bus.PCWriteCond, bus.PCWrite,
                 bus.IorD, bus.MemToReg, bus.IRWrite, bus.MemWrite,
                 bus.ALUControl, bus.trap, bus.illegal, bus.state_o};

  localparam logic [22:0] E_ZERO        = 23'd0;
  localparam logic [22:0] E_FETCH       = {2'b00, 2'b01, 1'b0, 8'b0001_0010, 4'b0010, 2'b00, 4'd0};
  localparam logic [22:0] E_DECODE      = {2'b00, 2'b11, 1'b0, 8'b0000_0000, 4'b0010, 2'b00, 4'd1};
  localparam logic [22:0] E_ILLEGAL     = {2'b00, 2'b11, 1'b0, 8'b0000_0000, 4'b0010, 2'b01, 4'd1};
  localparam logic [22:0] E_MEMADR      = {2'b00, 2'b10, 1'b1, 8'b0000_0000, 4'b0010, 2'b00, 4'd2};
  localparam logic [22:0] E_MEMRD       = {2'b00, 2'b00, 1'b0, 8'b0000_1000, 4'b0000, 2'b00, 4'd3};
  localparam logic [22:0] E_MEMWB       = {2'b00, 2'b00, 1'b0, 8'b1000_0100, 4'b0000, 2'b00, 4'd4};
  localparam logic [22:0] E_MEMWR       = {2'b00, 2'b00, 1'b0, 8'b0000_1001, 4'b0000, 2'b00, 4'd5};
  localparam logic [22:0] E_ALUWB       = {2'b00, 2'b00, 1'b0, 8'b1100_0000, 4'b0000, 2'b00, 4'd7};
  localparam logic [22:0] E_ALUWB_TRAP  = {2'b00, 2'b00, 1'b0, 8'b0100_0000, 4'b0000, 2'b10, 4'd7};
  localparam logic [22:0] E_BRANCH      = {2'b01, 2'b00, 1'b1, 8'b0010_0000, 4'b0110, 2'b00, 4'd8};
  localparam logic [22:0] E_ADDIEXEC    = {2'b00, 2'b10, 1'b1, 8'b0000_0000, 4'b0010, 2'b00, 4'd9};
  localparam logic [22:0] E_ADDIWB      = {2'b00, 2'b00, 1'b0, 8'b1000_0000, 4'b0000, 2'b00, 4'd10};
  localparam logic [22:0] E_ADDIWB_TRAP = {2'b00, 2'b00, 1'b0, 8'b0000_0000, 4'b0000, 2'b10, 4'd10};
  localparam logic [22:0] E_JUMP        = {2'b10, 2'b00, 1'b0, 8'b0001_0000, 4'b0000, 2'b00, 4'd11};

  function automatic logic [22:0] e_execute(input logic [3:0] alu);
    return {2'b00, 2'b00, 1'b1, 8'b0000_0000, alu, 2'b00, 4'd6};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instruction = 32'h8C22_0004;
    bus.overflow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (ctrl !== E_ZERO) begin
        tests_failed++;
        $display("[TB] FAIL reset_hold[%0d]: got %h, want %h", i, ctrl, E_ZERO);
      end
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== E_FETCH) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got %h, want %h", ctrl, E_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [22:0] seq [6];
    seq = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
    bus.instruction = 32'h8C22_0004;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (ctrl !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL lw[%0d]: got %h, want %h", i, ctrl, seq[i]);
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_sw();
    logic [22:0] seq [5];
    seq = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
    bus.instruction = 32'hAC22_0008;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (ctrl !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL sw[%0d]: got %h, want %h", i, ctrl, seq[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_rtype();
    logic [5:0]  functs [6];
    logic [3:0]  alus   [6];
    logic [22:0] seq    [5];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    alus   = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
    for (int k = 0; k < 6; k++) begin
      bus.instruction = {26'b000000_00001_00010_00011_00000, functs[k]};
      seq = '{E_FETCH, E_DECODE, e_execute(alus[k]), E_ALUWB, E_FETCH};
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (ctrl !== seq[i]) begin
          tests_failed++;
          $display("[TB] FAIL rtype_f%h[%0d]: got %h, want %h", functs[k], i, ctrl, seq[i]);
        end
        if (i < 4) tick();
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [22:0] seq_b [4];
    logic [22:0] seq_j [4];
    seq_b = '{E_FETCH, E_DECODE, E_BRANCH, E_FETCH};
    seq_j = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
    bus.instruction = 32'h1022_0003;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (ctrl !== seq_b[i]) begin
        tests_failed++;
        $display("[TB] FAIL beq[%0d]: got %h, want %h", i, ctrl, seq_b[i]);
      end
      if (i < 3) tick();
    end
    bus.instruction = 32'h0800_0010;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (ctrl !== seq_j[i]) begin
        tests_failed++;
        $display("[TB] FAIL j[%0d]: got %h, want %h", i, ctrl, seq_j[i]);
      end
      if (i < 3) tick();
    end
  endtask

  // Overflow is raised only while the instruction sits in its execute state.
  task automatic test_overflow();
    logic [31:0] instrs [3];
    logic [22:0] seq    [3][5];
    instrs = '{32'h2022_0005, 32'h0022_1821, 32'h0022_1820};
    seq[0] = '{E_FETCH, E_DECODE, E_ADDIEXEC, E_ADDIWB_TRAP, E_FETCH};
    seq[1] = '{E_FETCH, E_DECODE, e_execute(4'b0010), E_ALUWB, E_FETCH};
    seq[2] = '{E_FETCH, E_DECODE, e_execute(4'b0010), E_ALUWB_TRAP, E_FETCH};
    for (int k = 0; k < 3; k++) begin
      bus.instruction = instrs[k];
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (ctrl !== seq[k][i]) begin
          tests_failed++;
          $display("[TB] FAIL overflow_%0d[%0d]: got %h, want %h", k, i, ctrl, seq[k][i]);
        end
        bus.overflow = (i == 2);
        if (i < 4) tick();
      end
      bus.overflow = 1'b0;
    end
  endtask

  task automatic test_illegal();
    logic [22:0] seq [3];
    seq = '{E_FETCH, E_ILLEGAL, E_FETCH};
    bus.instruction = 32'hFC00_0000;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (ctrl !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL illegal[%0d]: got %h, want %h", i, ctrl, seq[i]);
      end
      if (i < 2) tick();
    end
  endtask

  task automatic test_reset_midway();
    bus.instruction = 32'hAC22_0008;
    tick();
    tick();
    tick();
    tests_run++;
    if (ctrl !== E_MEMWR) begin
      tests_failed++;
      $display("[TB] FAIL midreset_memwr: got %h, want %h", ctrl, E_MEMWR);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.MemWrite !== 1'b0 || ctrl !== E_ZERO) begin
      tests_failed++;
      $display("[TB] FAIL midreset_hold: got %h, want %h", ctrl, E_ZERO);
    end
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== E_FETCH) begin
      tests_failed++;
      $display("[TB] FAIL midreset_fetch: got %h, want %h", ctrl, E_FETCH);
    end
    bus.instruction = 32'h8C22_0004;
    tick();
    tests_run++;
    if (ctrl !== E_DECODE) begin
      tests_failed++;
      $display("[TB] FAIL midreset_decode: got %h, want %h", ctrl, E_DECODE);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_branch_jump();
    test_overflow();
    test_illegal();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
